// File: rtl/mac_col_pkg.sv
// ============================================================================
// Module  : mac_col_pkg
// Brief   : Shared instruction codes, pipeline beat type and the adder used
//           by the attention MAC column. Defining MAC_COL_SAT_EN makes
//           every accumulation saturate instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_col_pkg;

   typedef logic [1:0] inst_t;

   localparam inst_t INST_IDLE = 2'b00;
   localparam inst_t INST_LOAD = 2'b01;
   localparam inst_t INST_EXEC = 2'b10;
   localparam inst_t INST_CLR  = 2'b11;

`ifdef MAC_COL_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   // Control that travels alongside one execute word through the datapath.
   typedef struct packed {
      logic vld;
      logic first;
      logic last;
   } beat_t;

   // Adds two values that are already sign-extended from a w-bit field.
   // Saturated builds clamp to the w-bit signed range; otherwise the caller
   // truncates to w bits, giving modulo-2^w behaviour.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int              w);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = ~hi;
      if (SAT_EN) begin
         if (s > hi) begin
            s = hi;
         end else if (s < lo) begin
            s = lo;
         end
      end
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mac_col_if.sv
// ============================================================================
// Module  : mac_col_if
// Brief   : Word/instruction bus of one MAC column. The slave side is the
//           column itself; the master side feeds it and collects results and
//           the re-registered chain outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_col_if #(
   parameter int PR      = 8,
   parameter int BW      = 8,
   parameter int BW_PSUM = 32,
   parameter int SW      = 1
);
   logic [PR*BW-1:0]          q_in;
   logic [1:0]                i_inst;
   logic [SW-1:0]             i_kslot;
   logic [PR*BW-1:0]          q_out;
   logic [1:0]                o_inst;
   logic [SW-1:0]             o_kslot;
   logic signed [BW_PSUM-1:0] out;
   logic                      fifo_wr;

   modport master (
      output q_in, i_inst, i_kslot,
      input  q_out, o_inst, o_kslot, out, fifo_wr
   );

   modport slave (
      input  q_in, i_inst, i_kslot,
      output q_out, o_inst, o_kslot, out, fifo_wr
   );
endinterface

`default_nettype wire

// File: rtl/mac_col_dot.sv
// ============================================================================
// Module  : mac_col_dot
// Brief   : PR-lane signed multiplier register stage followed by a registered
//           adder tree. Beat control (valid/first/last) is carried alongside.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_col_dot
   import mac_col_pkg::*;
#(
   parameter int BW      = 8,
   parameter int BW_PSUM = 32,
   parameter int PR      = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [PR*BW-1:0]          q_i,
   input  logic [PR*BW-1:0]          k_i,
   input  beat_t                     beat_i,
   input  logic                      flush_i,
   output logic signed [BW_PSUM-1:0] sum_o,
   output beat_t                     beat_o
);

   localparam int LVLS = (PR > 1) ? $clog2(PR) : 0;
   localparam int NP   = 1 << LVLS;

   logic signed [2*BW-1:0]    prod_d [PR];
   logic signed [2*BW-1:0]    prod_q [PR];
   beat_t                     beat1_q;
   logic signed [BW_PSUM-1:0] sum_d;
   logic signed [BW_PSUM-1:0] sum_q;
   beat_t                     beat2_q;

   for (genvar l = 0; l < PR; l++) begin : g_lane
      assign prod_d[l] = $signed(q_i[l*BW +: BW]) * $signed(k_i[l*BW +: BW]);
   end

   // Pairwise reduction of the registered products, padded to a power of two.
   always_comb begin
      logic signed [BW_PSUM-1:0] t [NP];
      for (int i = 0; i < NP; i++) begin
         t[i] = '0;
      end
      for (int i = 0; i < PR; i++) begin
         t[i] = BW_PSUM'(prod_q[i]);
      end
      for (int lv = 0; lv < LVLS; lv++) begin
         for (int i = 0; i < (NP >> (lv + 1)); i++) begin
            t[i] = BW_PSUM'(sat_add(64'(t[2*i]), 64'(t[2*i+1]), BW_PSUM));
         end
      end
      sum_d = t[0];
   end

   // Product stage and tree-sum stage; a clear drops any word in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int l = 0; l < PR; l++) begin
            prod_q[l] <= '0;
         end
         beat1_q <= '0;
         sum_q   <= '0;
         beat2_q <= '0;
      end else begin
         for (int l = 0; l < PR; l++) begin
            prod_q[l] <= prod_d[l];
         end
         beat1_q <= flush_i ? beat_t'('0) : beat_i;
         sum_q   <= sum_d;
         beat2_q <= flush_i ? beat_t'('0) : beat1_q;
      end
   end

   assign sum_o  = sum_q;
   assign beat_o = beat2_q;

endmodule

`default_nettype wire

// File: rtl/mac_col_mk.sv
// ============================================================================
// Module  : mac_col_mk
// Brief   : Attention MAC column. Holds K_DEPTH key vectors of CHUNKS words,
//           streams Q words and emits one signed dot product per Q vector
//           with a fifo_wr strobe. Q, instruction and key-slot select are
//           re-registered for the next column. Build option MAC_COL_SAT_EN
//           saturates the accumulator instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_col_mk
   import mac_col_pkg::*;
#(
   parameter int BW      = 8,
   parameter int BW_PSUM = 32,
   parameter int PR      = 8,
   parameter int COL_ID  = 0,
   parameter int NUM_COL = 8,
   parameter int K_DEPTH = 2,
   parameter int CHUNKS  = 1
) (
   input  logic     clk,
   input  logic     reset,
   mac_col_if.slave bus
);

   localparam int WW = PR * BW;
   localparam int SW = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
   localparam int EW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int CW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
   localparam int RW = $clog2(K_DEPTH + 1);

   logic [WW-1:0]             kmem_q [K_DEPTH][CHUNKS];
   logic [EW-1:0]             lc_c_q;
   logic [CW-1:0]             lc_col_q;
   logic [RW-1:0]             lc_row_q;
   logic [EW-1:0]             ec_q;
   logic signed [BW_PSUM-1:0] acc_q;
   logic signed [BW_PSUM-1:0] acc_d;
   logic signed [BW_PSUM-1:0] out_q;
   logic                      fifo_wr_q;
   logic [WW-1:0]             q_out_q;
   logic [1:0]                o_inst_q;
   logic [SW-1:0]             o_kslot_q;

   logic                      is_load;
   logic                      is_exec;
   logic                      is_clr;
   logic                      ld_hit;
   logic [WW-1:0]             k_sel;
   beat_t                     beat_in;
   beat_t                     beat2;
   logic signed [BW_PSUM-1:0] sum;

   // Instruction decode.
   always_comb begin
      is_load = 1'b0;
      is_exec = 1'b0;
      is_clr  = 1'b0;
      case (bus.i_inst)
         INST_IDLE: ;
         INST_LOAD: is_load = 1'b1;
         INST_EXEC: is_exec = 1'b1;
         INST_CLR:  is_clr  = 1'b1;
      endcase
   end

   // The load counter is kept as (row, column, chunk) so no divider is needed.
   assign ld_hit = is_load && (lc_col_q == CW'(COL_ID)) && (lc_row_q < RW'(K_DEPTH));

   // Load word counter; restarts whenever the instruction is not a load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lc_c_q   <= '0;
         lc_col_q <= '0;
         lc_row_q <= '0;
      end else if (!is_load) begin
         lc_c_q   <= '0;
         lc_col_q <= '0;
         lc_row_q <= '0;
      end else if (lc_c_q == EW'(CHUNKS - 1)) begin
         lc_c_q <= '0;
         if (lc_col_q == CW'(NUM_COL - 1)) begin
            lc_col_q <= '0;
            if (lc_row_q != RW'(K_DEPTH)) begin
               lc_row_q <= lc_row_q + 1'b1;
            end
         end else begin
            lc_col_q <= lc_col_q + 1'b1;
         end
      end else begin
         lc_c_q <= lc_c_q + 1'b1;
      end
   end

   // Key memory: written only by words that belong to this column.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < K_DEPTH; s++) begin
            for (int c = 0; c < CHUNKS; c++) begin
               kmem_q[s][c] <= '0;
            end
         end
      end else if (is_clr) begin
         for (int s = 0; s < K_DEPTH; s++) begin
            for (int c = 0; c < CHUNKS; c++) begin
               kmem_q[s][c] <= '0;
            end
         end
      end else if (ld_hit) begin
         for (int s = 0; s < K_DEPTH; s++) begin
            for (int c = 0; c < CHUNKS; c++) begin
               if ((lc_row_q == RW'(s)) && (lc_c_q == EW'(c))) begin
                  kmem_q[s][c] <= bus.q_in;
               end
            end
         end
      end
   end

   // Execute chunk counter; leaving execute abandons the current vector.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ec_q <= '0;
      end else if (!is_exec) begin
         ec_q <= '0;
      end else if (ec_q == EW'(CHUNKS - 1)) begin
         ec_q <= '0;
      end else begin
         ec_q <= ec_q + 1'b1;
      end
   end

   // Key word select; an out-of-range slot matches nothing and yields zero.
   always_comb begin
      k_sel = '0;
      for (int s = 0; s < K_DEPTH; s++) begin
         for (int c = 0; c < CHUNKS; c++) begin
            if ((bus.i_kslot == SW'(s)) && (ec_q == EW'(c))) begin
               k_sel = kmem_q[s][c];
            end
         end
      end
   end

   assign beat_in.vld   = is_exec;
   assign beat_in.first = (ec_q == '0);
   assign beat_in.last  = (ec_q == EW'(CHUNKS - 1));

   mac_col_dot #(
      .BW      (BW),
      .BW_PSUM (BW_PSUM),
      .PR      (PR)
   ) u_dot (
      .clk     (clk),
      .reset   (reset),
      .q_i     (bus.q_in),
      .k_i     (k_sel),
      .beat_i  (beat_in),
      .flush_i (is_clr),
      .sum_o   (sum),
      .beat_o  (beat2)
   );

   // The first chunk of a vector restarts the sum, discarding any partial.
   always_comb begin
      logic signed [BW_PSUM-1:0] base;
      base  = beat2.first ? '0 : acc_q;
      acc_d = BW_PSUM'(sat_add(64'(base), 64'(sum), BW_PSUM));
   end

   // Accumulator and result register with its one-cycle write strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         out_q     <= '0;
         fifo_wr_q <= 1'b0;
      end else if (is_clr) begin
         acc_q     <= '0;
         out_q     <= '0;
         fifo_wr_q <= 1'b0;
      end else begin
         fifo_wr_q <= beat2.vld && beat2.last;
         if (beat2.vld) begin
            acc_q <= acc_d;
         end
         if (beat2.vld && beat2.last) begin
            out_q <= acc_d;
         end
      end
   end

   // Systolic pass-through to the next column.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_out_q   <= '0;
         o_inst_q  <= '0;
         o_kslot_q <= '0;
      end else begin
         q_out_q   <= bus.q_in;
         o_inst_q  <= bus.i_inst;
         o_kslot_q <= bus.i_kslot;
      end
   end

   assign bus.q_out   = q_out_q;
   assign bus.o_inst  = o_inst_q;
   assign bus.o_kslot = o_kslot_q;
   assign bus.out     = out_q;
   assign bus.fifo_wr = fifo_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_col_mk.sv
// ============================================================================
// Module  : tb_mac_col_mk
// Brief   : Directed bench for mac_col_mk. Three columns with different
//           shapes share clock and reset: A (3 columns, this is column 1),
//           B (two chunks per vector) and C (16-bit accumulator, 3 slots).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_col_mk;
   import mac_col_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mac_col_if #(.PR(8), .BW(8), .BW_PSUM(32), .SW(1)) ifa ();
   mac_col_if #(.PR(8), .BW(8), .BW_PSUM(32), .SW(1)) ifb ();
   mac_col_if #(.PR(8), .BW(8), .BW_PSUM(16), .SW(2)) ifc ();

   mac_col_mk #(.BW(8), .BW_PSUM(32), .PR(8), .COL_ID(1), .NUM_COL(3),
                .K_DEPTH(2), .CHUNKS(1)) u_a (.clk(clk), .reset(reset), .bus(ifa));
   mac_col_mk #(.BW(8), .BW_PSUM(32), .PR(8), .COL_ID(0), .NUM_COL(3),
                .K_DEPTH(2), .CHUNKS(2)) u_b (.clk(clk), .reset(reset), .bus(ifb));
   mac_col_mk #(.BW(8), .BW_PSUM(16), .PR(8), .COL_ID(0), .NUM_COL(1),
                .K_DEPTH(3), .CHUNKS(1)) u_c (.clk(clk), .reset(reset), .bus(ifc));

   // Never reached on a healthy run; stops a hung simulation.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d (0x%h), expected %0d (0x%h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] splat(input logic [7:0] v);
      logic [63:0] r;
      for (int l = 0; l < 8; l++) r[l*8 +: 8] = v;
      return r;
   endfunction

   function automatic logic [63:0] ramp_up();
      logic [63:0] r;
      for (int l = 0; l < 8; l++) r[l*8 +: 8] = 8'(l + 1);
      return r;
   endfunction

   function automatic logic [63:0] ramp_dn();
      logic [63:0] r;
      for (int l = 0; l < 8; l++) r[l*8 +: 8] = 8'(8 - l);
      return r;
   endfunction

   task automatic drv_a(input logic [1:0] inst, input logic [63:0] q, input logic [0:0] ks);
      ifa.i_inst = inst; ifa.q_in = q; ifa.i_kslot = ks;
   endtask

   task automatic drv_b(input logic [1:0] inst, input logic [63:0] q, input logic [0:0] ks);
      ifb.i_inst = inst; ifb.q_in = q; ifb.i_kslot = ks;
   endtask

   task automatic drv_c(input logic [1:0] inst, input logic [63:0] q, input logic [1:0] ks);
      ifc.i_inst = inst; ifc.q_in = q; ifc.i_kslot = ks;
   endtask

   // One isolated Q vector on column A; result expected two edges after sampling.
   task automatic exec1_a(input string tag, input logic [63:0] q, input logic [0:0] ks,
                          input logic signed [63:0] exp);
      drv_a(INST_EXEC, q, ks);
      tick();
      drv_a(INST_IDLE, '0, '0);
      tick();
      chk({tag, " early strobe"}, 64'(ifa.fifo_wr), 0);
      tick();
      chk({tag, " strobe"}, 64'(ifa.fifo_wr), 1);
      chk({tag, " out"}, ifa.out, exp);
      tick();
      chk({tag, " strobe drop"}, 64'(ifa.fifo_wr), 0);
   endtask

   logic [63:0]        lw [8];
   logic               seen;
   logic signed [63:0] exp_sat;

   initial begin
      lw[0] = splat(8'd5);  lw[1] = ramp_up();    lw[2] = splat(8'd9);  lw[3] = splat(8'd3);
      lw[4] = ramp_dn();    lw[5] = splat(8'd7);  lw[6] = splat(8'd11); lw[7] = splat(8'd100);
`ifdef MAC_COL_SAT_EN
      exp_sat = 32767;
`else
      exp_sat = -2040;
`endif

      // Reset state
      reset = 1'b1;
      drv_a(INST_IDLE, '0, '0);
      drv_b(INST_IDLE, '0, '0);
      drv_c(INST_IDLE, '0, '0);
      tick();
      tick();
      chk("reset out", ifa.out, 0);
      chk("reset fifo_wr", 64'(ifa.fifo_wr), 0);
      chk("reset q_out", ifa.q_out, 0);
      chk("reset o_inst", 64'(ifa.o_inst), 0);
      chk("reset o_kslot", 64'(ifa.o_kslot), 0);
      reset = 1'b0;
      tick();

      // Slot mapping: column 1 of 3 keeps v1 in slot 0 and v4 in slot 1; v7 overflows
      for (int i = 0; i < 8; i++) begin
         drv_a(INST_LOAD, lw[i], '0);
         tick();
      end
      drv_a(INST_IDLE, '0, '0);
      tick();
      exec1_a("map s0 ones", splat(8'd1), 1'b0, 36);
      exec1_a("map s1 ones", splat(8'd1), 1'b1, 36);
      exec1_a("map s1 lane0", 64'd1, 1'b1, 8);
      exec1_a("map s0 lane0", 64'd1, 1'b0, 1);

      // Back-to-back words and pass-through delay
      drv_a(INST_EXEC, splat(8'd1), 1'b0);
      tick();
      chk("pass q_out w1", ifa.q_out, splat(8'd1));
      chk("pass o_inst w1", 64'(ifa.o_inst), 64'(INST_EXEC));
      chk("pass o_kslot w1", 64'(ifa.o_kslot), 0);
      drv_a(INST_EXEC, 64'd1, 1'b1);
      tick();
      chk("b2b no strobe yet", 64'(ifa.fifo_wr), 0);
      chk("pass q_out w2", ifa.q_out, 64'd1);
      chk("pass o_kslot w2", 64'(ifa.o_kslot), 1);
      drv_a(INST_EXEC, splat(8'd2), 1'b0);
      tick();
      chk("b2b strobe 1", 64'(ifa.fifo_wr), 1);
      chk("b2b out 1", ifa.out, 36);
      drv_a(INST_IDLE, '0, '0);
      tick();
      chk("b2b strobe 2", 64'(ifa.fifo_wr), 1);
      chk("b2b out 2", ifa.out, 8);
      chk("pass o_inst idle", 64'(ifa.o_inst), 64'(INST_IDLE));
      tick();
      chk("b2b strobe 3", 64'(ifa.fifo_wr), 1);
      chk("b2b out 3", ifa.out, 72);
      tick();
      chk("b2b strobe end", 64'(ifa.fifo_wr), 0);
      chk("b2b out held", ifa.out, 72);

      // Two chunks per vector
      drv_b(INST_LOAD, ramp_up(), '0);
      tick();
      drv_b(INST_LOAD, ramp_up(), '0);
      tick();
      drv_b(INST_IDLE, '0, '0);
      tick();
      drv_b(INST_EXEC, splat(8'd1), 1'b0);
      tick();
      drv_b(INST_EXEC, splat(8'd2), 1'b0);
      tick();
      drv_b(INST_IDLE, '0, '0);
      tick();
      chk("chunk no mid strobe", 64'(ifb.fifo_wr), 0);
      tick();
      chk("chunk strobe", 64'(ifb.fifo_wr), 1);
      chk("chunk out", ifb.out, 108);
      tick();
      chk("chunk strobe drop", 64'(ifb.fifo_wr), 0);

      // Abandoned vector, then clear
      drv_b(INST_EXEC, splat(8'd1), 1'b0);
      tick();
      drv_b(INST_IDLE, '0, '0);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen = seen | ifb.fifo_wr;
      end
      chk("abort no strobe", 64'(seen), 0);
      chk("abort out held", ifb.out, 108);
      drv_b(INST_EXEC, splat(8'd2), 1'b0);
      tick();
      drv_b(INST_EXEC, splat(8'd2), 1'b0);
      tick();
      drv_b(INST_IDLE, '0, '0);
      tick();
      tick();
      chk("after abort strobe", 64'(ifb.fifo_wr), 1);
      chk("after abort out", ifb.out, 144);
      drv_b(INST_CLR, '0, '0);
      tick();
      chk("clear out", ifb.out, 0);
      drv_b(INST_IDLE, '0, '0);
      tick();
      drv_b(INST_EXEC, splat(8'd1), 1'b0);
      tick();
      drv_b(INST_EXEC, splat(8'd1), 1'b0);
      tick();
      drv_b(INST_IDLE, '0, '0);
      tick();
      tick();
      chk("cleared kmem strobe", 64'(ifb.fifo_wr), 1);
      chk("cleared kmem out", ifb.out, 0);

      // 16-bit accumulator: overflow, negative keys, out-of-range slot
      drv_c(INST_LOAD, splat(8'd127), '0);
      tick();
      drv_c(INST_LOAD, splat(8'hFF), '0);
      tick();
      drv_c(INST_IDLE, '0, '0);
      tick();
      drv_c(INST_EXEC, splat(8'd127), 2'd0);
      tick();
      drv_c(INST_EXEC, splat(8'd127), 2'd1);
      tick();
      drv_c(INST_EXEC, splat(8'd127), 2'd3);
      tick();
      drv_c(INST_IDLE, '0, '0);
      chk("ovf out", ifc.out, exp_sat);
      chk("ovf strobe", 64'(ifc.fifo_wr), 1);
      tick();
      chk("neg key out", ifc.out, -1016);
      tick();
      chk("bad slot out", ifc.out, 0);
      chk("bad slot strobe", 64'(ifc.fifo_wr), 1);
      tick();

      // Asynchronous reset in the middle of an execute
      drv_a(INST_EXEC, splat(8'd1), 1'b0);
      tick();
      chk("pre-reset q_out", ifa.q_out, splat(8'd1));
      drv_a(INST_IDLE, '0, '0);
      #2 reset = 1'b1;
      #1;
      chk("async rst out", ifa.out, 0);
      chk("async rst fifo_wr", 64'(ifa.fifo_wr), 0);
      chk("async rst q_out", ifa.q_out, 0);
      #1 reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen = seen | ifa.fifo_wr;
      end
      chk("post-reset no strobe", 64'(seen), 0);
      chk("post-reset out", ifa.out, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
